// File: rtl/serial_pkg.sv
// Shared definitions for the framed serial link (transmitter and matching receiver).
package serial_pkg;
  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] START = 2'b01;
  localparam logic [1:0] DATA  = 2'b10;
  localparam logic [1:0] STOP  = 2'b11;

  localparam logic LINE_IDLE = 1'b1;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/bit_tick_gen.sv
// Bit-period timer: tick is high in the last clock cycle of every serial bit.
module bit_tick_gen
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int CW = cw(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  // Wraps explicitly at LAST so non-power-of-two periods stay exact.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              cnt <= '0;
    else if (clr || tick)  cnt <= '0;
    else                   cnt <= cnt + CW'(1);
  end
endmodule

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit, DATA_W data bits LSB-first, stop bit.
module serial_frame_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_bit,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state
);
  localparam int BW = cw(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  logic [1:0]        state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt, shr;
  logic [BW-1:0]     bcnt, bcnt_nxt;
  logic              out_nxt, done_nxt;
  logic              tick;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign shr      = shreg >> 1;

  // Held clear through IDLE so START always gets a full bit period.
  bit_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state == IDLE),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = START;
      START:   if (tick) state_nxt = DATA;
      DATA:    if (tick && bcnt == LAST_BIT) state_nxt = STOP;
      STOP:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    shreg_nxt = shreg;
    bcnt_nxt  = bcnt;
    out_nxt   = out_bit;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        out_nxt = LINE_IDLE;
        if (in_valid) begin
          shreg_nxt = in_data;
          out_nxt   = 1'b0;
        end
      end
      START: if (tick) begin
        out_nxt  = shreg[0];
        bcnt_nxt = '0;
      end
      DATA: if (tick) begin
        shreg_nxt = shr;
        bcnt_nxt  = bcnt + BW'(1);
        out_nxt   = (bcnt == LAST_BIT) ? LINE_IDLE : shr[0];
      end
      STOP: if (tick) done_nxt = 1'b1;
      default: out_nxt = LINE_IDLE;
    endcase
  end

  // Outputs are registered so the line never glitches.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bcnt    <= '0;
      out_bit <= LINE_IDLE;
      done    <= 1'b0;
    end else begin
      shreg   <= shreg_nxt;
      bcnt    <= bcnt_nxt;
      out_bit <= out_nxt;
      done    <= done_nxt;
    end
  end
endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx across three parameter sets.
module tb_serial_frame_tx;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0]      iv  = '0;
  logic [2:0][7:0] id  = '0;
  logic [2:0]      ob, bz, dn, rdy;
  logic [2:0][1:0] st;
  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  int prev_start = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(id[0]),
    .out_bit(ob[0]), .busy(bz[0]), .done(dn[0]), .state(st[0]));
  serial_frame_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(id[1]),
    .out_bit(ob[1]), .busy(bz[1]), .done(dn[1]), .state(st[1]));
  serial_frame_tx #(.DATA_W(1), .CLKS_PER_BIT(3)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]), .in_data(id[2][0:0]),
    .out_bit(ob[2]), .busy(bz[2]), .done(dn[2]), .state(st[2]));

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic [9:0] exp;    // bit i = i-th bit on the line
    int         nb;
    int         cpb;
    bit         hold;   // keep in_valid high into the next frame
    bit         pre;    // this frame is accepted straight off the previous done cycle
    logic [7:0] after;  // in_data driven after the accept edge
    bit         poke;   // pulse in_valid with 8'h3C during DATA
  } vec_t;

  vec_t tbl [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk); #1;
  endtask

  task automatic run(input vec_t v);
    int k = 0;
    logic [1:0] es;
    if (!v.pre) begin
      iv[v.sel] = 1'b1;
      id[v.sel] = v.data;
    end
    tick1();  // accept edge
    if (v.pre) chk("b2b_period", cyc - prev_start, v.nb * v.cpb + 1);
    prev_start = cyc;
    iv[v.sel] = v.hold;
    id[v.sel] = v.after;
    for (int i = 0; i < v.nb; i++) begin
      es = (i == 0) ? 2'b01 : (i == v.nb - 1) ? 2'b11 : 2'b10;
      for (int c = 0; c < v.cpb; c++) begin
        chk("out_bit", ob[v.sel], v.exp[i]);
        chk("state", st[v.sel], es);
        chk("in_ready_busy", {rdy[v.sel], bz[v.sel], dn[v.sel]}, 3'b010);
        if (v.poke && k == 3 * v.cpb) begin
          iv[v.sel] = 1'b1;
          id[v.sel] = 8'h3C;
        end else if (v.poke) begin
          iv[v.sel] = 1'b0;
        end
        k++;
        tick1();
      end
    end
    chk("done_pulse", {dn[v.sel], st[v.sel], rdy[v.sel], ob[v.sel]}, 5'b1_00_1_1);
    if (!v.hold) begin
      for (int j = 0; j < 3; j++) begin
        tick1();
        chk("idle_line", {dn[v.sel], st[v.sel], ob[v.sel], bz[v.sel]}, 5'b0_00_1_0);
      end
    end
  endtask

  initial begin
    tbl[0] = '{0, 8'hA5, 10'h34A, 10, 4, 1'b0, 1'b0, 8'h5A, 1'b0};
    tbl[1] = '{0, 8'h00, 10'h200, 10, 4, 1'b1, 1'b0, 8'hFF, 1'b0};
    tbl[2] = '{0, 8'hFF, 10'h3FE, 10, 4, 1'b0, 1'b1, 8'h00, 1'b0};
    tbl[3] = '{0, 8'hC3, 10'h386, 10, 4, 1'b0, 1'b0, 8'hC3, 1'b1};
    tbl[4] = '{1, 8'h81, 10'h302, 10, 1, 1'b0, 1'b0, 8'h7E, 1'b0};
    tbl[5] = '{2, 8'h01, 10'h006,  3, 3, 1'b0, 1'b0, 8'h00, 1'b0};

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++) begin
      iv = 3'($urandom);
      id = 24'($urandom);
      tick1();
      for (int d = 0; d < 3; d++)
        chk("reset_state", {ob[d], st[d], rdy[d], bz[d], dn[d]}, 6'b1_00_1_0_0);
    end
    iv = '0;
    rst = 1'b1;
    tick1();

    foreach (tbl[i]) run(tbl[i]);

    // Reset mid-frame aborts at once; the line returns high without a clock edge.
    iv[0] = 1'b1;
    id[0] = 8'h00;
    tick1();
    iv[0] = 1'b0;
    repeat (14) tick1();
    chk("mid_state_data", st[0], 2'b10);
    chk("mid_line_low", ob[0], 1'b0);
    rst = 1'b0;
    #1;
    chk("abort_line", {ob[0], st[0], bz[0], rdy[0]}, 5'b1_00_0_1);
    tick1();
    rst = 1'b1;
    iv[0] = 1'b1;
    id[0] = 8'hA5;
    tick1();
    chk("accept_after_reset", {ob[0], st[0]}, 3'b0_01);
    iv[0] = 1'b0;
    repeat (44) tick1();
    chk("recovered_idle", {ob[0], st[0]}, 3'b1_00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
